// File: rtl/soc_sysid_regs.sv
// soc_sysid_regs: Avalon-MM system-ID slave with RO ID words, scratch, and 64-bit uptime counter
module soc_sysid_regs #(
    parameter logic [31:0] SYS_ID       = 32'h63B6597C,
    parameter logic [31:0] TIMESTAMP    = 32'h00000000,
    parameter logic [31:0] VERSION      = 32'h00020000,
    parameter int          READ_LATENCY = 1,
    parameter logic [63:0] UPTIME_RESET = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("soc_sysid_regs: READ_LATENCY must be 1..4");
    end

    logic [31:0]                   scratch_q, scratch_d;
    logic                          freeze_q, freeze_d;
    logic [63:0]                   cnt_q, cnt_d;
    logic [31:0]                   shadow_q, shadow_d;
    logic [READ_LATENCY-1:0][31:0] pipe_data_q, pipe_data_d;
    logic [READ_LATENCY-1:0]       pipe_vld_q, pipe_vld_d;
    logic [31:0]                   rdata;
    logic                          wr_en;
    logic                          ctrl_wr;
    logic                          clear;

    // a simultaneous read wins; the write in that cycle is dropped
    assign wr_en   = write & ~read;
    assign ctrl_wr = wr_en && address == 3'd6 && byteenable[0];
    assign clear   = ctrl_wr && writedata[1];

    // scratch byte-lane writes, CTRL freeze bit, uptime counter and the coherent high-word snapshot
    always_comb begin
        scratch_d = scratch_q;
        for (int b = 0; b < 4; b++)
            if (wr_en && address == 3'd3 && byteenable[b])
                scratch_d[8*b +: 8] = writedata[8*b +: 8];
        freeze_d = ctrl_wr ? writedata[0] : freeze_q;
        cnt_d    = clear ? UPTIME_RESET : freeze_q ? cnt_q : cnt_q + 64'd1;
        shadow_d = (read && address == 3'd4) ? cnt_q[63:32] : shadow_q;
    end

    // read data selection, sampled in the strobe cycle
    always_comb begin
        case (address)
            3'd0:    rdata = SYS_ID;
            3'd1:    rdata = TIMESTAMP;
            3'd2:    rdata = VERSION;
            3'd3:    rdata = scratch_q;
            3'd4:    rdata = cnt_q[31:0];
            3'd5:    rdata = shadow_q;
            3'd6:    rdata = {31'd0, freeze_q};
            default: rdata = 32'd0;
        endcase
    end

    // response pipeline; data stages only load behind a valid so the output holds between responses
    always_comb begin
        pipe_vld_d     = '0;
        pipe_data_d    = pipe_data_q;
        pipe_vld_d[0]  = read;
        pipe_data_d[0] = read ? rdata : pipe_data_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_vld_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
        end
    end

    // state registers; reset flushes any in-flight response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch_q   <= '0;
            freeze_q    <= 1'b0;
            cnt_q       <= UPTIME_RESET;
            shadow_q    <= '0;
            pipe_data_q <= '0;
            pipe_vld_q  <= '0;
        end else begin
            scratch_q   <= scratch_d;
            freeze_q    <= freeze_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            pipe_data_q <= pipe_data_d;
            pipe_vld_q  <= pipe_vld_d;
        end
    end

    assign readdata      = pipe_data_q[READ_LATENCY-1];
    assign readdatavalid = pipe_vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_soc_sysid_regs.sv
// tb_soc_sysid_regs: scoreboard bench driving two instances (latency 2 and 3) with shared stimulus
module tb_soc_sysid_regs;

    localparam logic [63:0] UR  = 64'h0000_0000_FFFF_FFF0;
    localparam logic [31:0] SID = 32'h63B6597C;
    localparam logic [31:0] TS  = 32'h6543_2100;
    localparam logic [31:0] VER = 32'h00020000;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] rd2, rd3;
    logic        v2, v3;

    exp_t        q2[$];
    exp_t        q3[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_cnt = UR;
    logic        m_frz = 1'b0;
    logic [31:0] m_shd = '0;

    always #5 clock = ~clock;

    soc_sysid_regs #(.SYS_ID(SID), .TIMESTAMP(TS), .VERSION(VER), .READ_LATENCY(2), .UPTIME_RESET(UR)) dut2 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd2), .readdatavalid(v2)
    );

    soc_sysid_regs #(.SYS_ID(SID), .TIMESTAMP(TS), .VERSION(VER), .READ_LATENCY(3), .UPTIME_RESET(UR)) dut3 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd3), .readdatavalid(v3)
    );

    // scoreboard: pop and compare whenever either instance produces a response
    task automatic sample();
        exp_t e;
        if (v2) begin
            n_cmp++;
            if (q2.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_lat2 unexpected: got %h at cycle %0d, required no response", rd2, cyc);
            end else begin
                e = q2.pop_front();
                if (rd2 !== e.d || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL rsp_lat2: got %h at cycle %0d, required %h at cycle %0d", rd2, cyc, e.d, e.due);
                end
            end
        end
        if (v3) begin
            n_cmp++;
            if (q3.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_lat3 unexpected: got %h at cycle %0d, required no response", rd3, cyc);
            end else begin
                e = q3.pop_front();
                if (rd3 !== e.d || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL rsp_lat3: got %h at cycle %0d, required %h at cycle %0d", rd3, cyc, e.d, e.due);
                end
            end
        end
    endtask

    // one clock: check outputs at negedge, advance the uptime model at posedge, drive after +1
    task automatic tick();
        logic c;
        @(negedge clock);
        sample();
        @(posedge clock);
        cyc++;
        c = write && !read && address == 3'd6 && byteenable[0];
        if (reset) begin
            m_cnt = UR;
            m_frz = 1'b0;
            m_shd = '0;
            q2.delete();
            q3.delete();
        end else begin
            if (c && writedata[1]) m_cnt = UR;
            else if (!m_frz) m_cnt = m_cnt + 64'd1;
            if (c) m_frz = writedata[0];
        end
        #1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e);
        exp_t x;
        x.d   = e;
        x.due = cyc + 2;
        q2.push_back(x);
        x.due = cyc + 3;
        q3.push_back(x);
        address = a;
        read    = 1'b1;
        tick();
        read    = 1'b0;
    endtask

    task automatic rd4();
        logic [31:0] e;
        e     = m_cnt[31:0];
        m_shd = m_cnt[63:32];
        rd(3'd4, e);
    endtask

    task automatic rd5();
        rd(3'd5, m_shd);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        address    = a;
        writedata  = d;
        byteenable = be;
        write      = 1'b1;
        tick();
        write      = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q2.size() != 0 || q3.size() != 0); i++) tick();
        n_cmp++;
        if (q2.size() != 0 || q3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", q2.size(), q3.size());
        end
    endtask

    task automatic do_reset();
        read   = 1'b0;
        write  = 1'b0;
        reset  = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({v2, v3, rd2, rd3} !== 66'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b%b d=%h/%h, required 0", v2, v3, rd2, rd3);
        end
        rd(3'd0, SID);
        n_cmp++;
        if ({v2, v3, rd2, rd3} !== 66'd0) begin
            n_bad++;
            $display("FAIL pre_response: got v=%b%b d=%h/%h, required 0", v2, v3, rd2, rd3);
        end
        drain();
        n_cmp++;
        if (v2 !== 1'b0 || rd2 !== SID || rd3 !== SID) begin
            n_bad++;
            $display("FAIL readdata_hold: got v=%b d=%h/%h, required 0 %h", v2, rd2, rd3, SID);
        end
    endtask

    task automatic test_back_to_back();
        rd(3'd0, SID);
        rd(3'd1, TS);
        rd(3'd2, VER);
        rd(3'd7, 32'd0);
        drain();
    endtask

    task automatic test_scratch();
        wr(3'd3, 32'hDEADBEEF, 4'b1111);
        wr(3'd3, 32'h0000_0055, 4'b0001);
        rd(3'd3, 32'hDEADBE55);
        wr(3'd3, 32'hAABBCCDD, 4'b1010);
        rd(3'd3, 32'hAAADCC55);
        wr(3'd0, 32'hFFFFFFFF, 4'b1111);
        rd(3'd0, SID);
        wr(3'd7, 32'h12345678, 4'b1111);
        rd(3'd7, 32'd0);
        drain();
    endtask

    task automatic test_uptime_carry();
        do_reset();
        repeat (16) tick();
        rd(3'd4, 32'h0000_0000);
        m_shd = 32'h0000_0001;
        rd(3'd5, 32'h0000_0001);
        repeat (5) tick();
        rd(3'd5, 32'h0000_0001);
        rd4();
        rd5();
        drain();
    endtask

    task automatic test_freeze_clear();
        wr(3'd6, 32'h1, 4'b1111);
        rd4();
        repeat (10) tick();
        rd4();
        rd(3'd6, 32'h1);
        drain();
        wr(3'd6, 32'h3, 4'b1111);
        rd(3'd4, UR[31:0]);
        m_shd = UR[63:32];
        repeat (5) tick();
        rd4();
        rd5();
        rd(3'd6, 32'h1);
        wr(3'd6, 32'h0, 4'b1111);
        repeat (3) tick();
        rd4();
        rd(3'd6, 32'h0);
        drain();
    endtask

    task automatic test_reset_midflight();
        wr(3'd3, 32'h12345678, 4'b1111);
        wr(3'd6, 32'h1, 4'b1111);
        rd(3'd0, SID);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (v2 !== 1'b0 || v3 !== 1'b0 || rd2 !== 32'd0 || rd3 !== 32'd0) begin
                n_bad++;
                $display("FAIL flushed_rsp: got v=%b%b d=%h/%h, required 0", v2, v3, rd2, rd3);
            end
            tick();
        end
        rd(3'd3, 32'd0);
        rd(3'd6, 32'd0);
        rd4();
        writedata  = 32'hFFFFFFFF;
        byteenable = 4'b1111;
        write      = 1'b1;
        rd(3'd3, 32'd0);
        write      = 1'b0;
        rd(3'd3, 32'd0);
        drain();
    endtask

    initial begin
        #2;
        test_reset();
        test_back_to_back();
        test_scratch();
        test_uptime_carry();
        test_freeze_clear();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
